// File: rtl/mergesort_pkg.sv
// Shared constants for the mergesort memory and its reader/loader blocks.
//   WORD_W / DEPTH / ADDR_W : geometry of one sorted list (32 x 8-bit).
//   ST_*                    : 3-bit state encoding of the list reader FSM.
package mergesort_pkg;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/mergelist_order_check.sv
// Order checker for the streamed list: remembers the previously accepted word
// and raises a sticky flag when an accepted word is smaller (unsigned).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : new pass accepted, drop the sticky flag
//   accept_i   : a word is being handed off this cycle
//   first_i    : the word being handed off is index 0 (nothing to compare to)
//   data_i     : the word being handed off
//   err_o      : sticky out-of-order flag
module mergelist_order_check #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              first_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              err_o
);

  logic [WORD_W-1:0] prev_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (clear_i) begin
        err_q <= 1'b0;
      end else if (accept_i && !first_i && (data_i < prev_q)) begin
        err_q <= 1'b1;
      end
      if (accept_i) begin
        prev_q <= data_i;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mergelist_reader.sv
// Read side of the sort memory: walks the sorted list from address 0 to
// DEPTH-1 and streams each word on a valid/ready interface, 3 cycles per word.
// Optional feature: define MERGELIST_SORT_CHECK_EN to flag descending pairs
// on sort_err; otherwise sort_err is tied low.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a pass (only honoured in IDLE)
//   busy, done : pass in progress / one-cycle end-of-pass pulse
//   mem_addr   : registered read address, mem_rdata returns one cycle later
//   out_*      : streamed word with index and last marker, valid/ready
//   sort_err   : sticky out-of-order indication for the current pass
module mergelist_reader #(
  parameter int WORD_W = mergesort_pkg::WORD_W,
  parameter int DEPTH  = mergesort_pkg::DEPTH,
  parameter int ADDR_W = mergesort_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_index,
  output logic              sort_err
);
  import mergesort_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] out_index_q;
  logic [WORD_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              start_acc;
  logic              handshake;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign handshake = (state_q == ST_PRESENT) && out_valid_q && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_PRESENT;
      ST_PRESENT: begin
        if (handshake) begin
          state_d = out_last_q ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; busy is already low in the DONE cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_FETCH, ST_CAPTURE, ST_PRESENT: busy = 1'b1;
      ST_DONE:                          done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: address counter and the output holding register. The output
  // fields only load in CAPTURE, so they stay frozen while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        mem_addr_q <= '0;
      end
      if (state_q == ST_CAPTURE) begin
        out_data_q  <= mem_rdata;
        out_index_q <= mem_addr_q;
        out_last_q  <= (mem_addr_q == LAST_ADDR);
        out_valid_q <= 1'b1;
      end
      if (handshake) begin
        out_valid_q <= 1'b0;
        // The last address is never incremented, so mem_addr cannot wrap.
        if (!out_last_q) begin
          mem_addr_q <= mem_addr_q + 1'b1;
        end
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;

`ifdef MERGELIST_SORT_CHECK_EN
  mergelist_order_check #(
    .WORD_W (WORD_W)
  ) u_order_check (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_acc),
    .accept_i (handshake),
    .first_i  (out_index_q == '0),
    .data_i   (out_data_q),
    .err_o    (sort_err)
  );
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_mergelist_reader.sv
module tb_mergelist_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic [4:0] out_index;
  logic       sort_err;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  bit err_model = 1'b0;

`ifdef MERGELIST_SORT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [4:0] index;
    logic       last;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Synchronous-read memory model: data one cycle after the address
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  mergelist_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .sort_err  (sort_err)
  );

  task automatic fill_ascending();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
  endtask

  task automatic push_pass();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 32; i++) begin
      e.data  = mem[i];
      e.index = 5'(i);
      e.last  = (i == 31);
      sb.push_back(e);
    end
  endtask

  // One full pass: start, stream all words, check the done pulse.
  task automatic run_pass(input bit rand_ready, input bit spam, input string tag);
    exp_t       e;
    int         first_valid;
    bit         finished;
    bit         hs;
    bit         hs_prev;
    bit         vld_prev;
    logic [7:0] d_prev;
    logic [4:0] i_prev;
    logic       l_prev;
    logic [7:0] prev_word;
    @(negedge clk);
    start = 1'b1;
    push_pass();
    @(negedge clk);
    start = 1'b0;
    err_model = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got=%b exp=1", tag, busy);
    end
    first_valid = -1;
    finished = 1'b0;
    hs_prev = 1'b0;
    vld_prev = 1'b0;
    d_prev = '0;
    i_prev = '0;
    l_prev = 1'b0;
    prev_word = '0;
    for (int cyc = 1; cyc < 2000 && !finished; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (spam) start = ($urandom_range(0, 3) == 0);
      checks++;
      if (sort_err !== err_model) begin
        errors++;
        $display("FAIL %s sort_err cyc=%0d got=%b exp=%b", tag, cyc, sort_err, err_model);
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (vld_prev && !hs_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== d_prev || out_index !== i_prev || out_last !== l_prev) begin
          errors++;
          $display("FAIL %s stall_stable v=%b d=%02h i=%0d l=%b exp v=1 d=%02h i=%0d l=%b",
                   tag, out_valid, out_data, out_index, out_last, d_prev, i_prev, l_prev);
        end
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = (out_valid === 1'b1) && out_ready;
      if (hs) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word d=%02h i=%0d exp none", tag, out_data, out_index);
          finished = 1'b1;
        end else begin
          e = sb.pop_front();
          $display("%s word idx=%0d data=%02h last=%b", tag, out_index, out_data, out_last);
          if (out_data !== e.data || out_index !== e.index || out_last !== e.last) begin
            errors++;
            $display("FAIL %s word got d=%02h i=%0d l=%b exp d=%02h i=%0d l=%b",
                     tag, out_data, out_index, out_last, e.data, e.index, e.last);
          end
          if (CHK_EN && e.index != 0 && e.data < prev_word) err_model = 1'b1;
          prev_word = e.data;
          if (e.last) finished = 1'b1;
        end
      end
      vld_prev = (out_valid === 1'b1);
      hs_prev = hs;
      d_prev = out_data;
      i_prev = out_index;
      l_prev = out_last;
    end
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout words_left=%0d exp 0", tag, sb.size());
    end
    checks++;
    if (first_valid != 3) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=3", tag, first_valid);
    end
    // DONE cycle; a start driven here lands on the DONE edge and must be ignored
    @(negedge clk);
    start = spam;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sort_err !== err_model) begin
      errors++;
      $display("FAIL %s done_cycle done=%b busy=%b valid=%b err=%b exp 1 0 0 %b",
               tag, done, busy, out_valid, sort_err, err_model);
    end
    if (done === 1'b1) done_count++;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done k=%0d done=%b busy=%b valid=%b exp 0 0 0",
                 tag, k, done, busy, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        sort_err !== 1'b0 || mem_addr !== 5'd0 || out_data !== 8'd0 || out_index !== 5'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b v=%b l=%b err=%b a=%0d d=%02h i=%0d exp all 0",
               busy, done, out_valid, out_last, sort_err, mem_addr, out_data, out_index);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored busy=%b exp 0", busy);
    end
    $display("reset checked");
  endtask

  task automatic test_ascending();
    fill_ascending();
    run_pass(1'b0, 1'b0, "ascending");
  endtask

  task automatic test_random_ready();
    fill_ascending();
    run_pass(1'b1, 1'b0, "random_ready");
  endtask

  task automatic test_sort_check();
    fill_ascending();
    mem[9] = 8'h20;
    mem[10] = 8'h05;
    run_pass(1'b1, 1'b0, "sort_check");
    checks++;
    if (sort_err !== CHK_EN) begin
      errors++;
      $display("FAIL sort_check sticky got=%b exp=%b", sort_err, CHK_EN);
    end
    fill_ascending();
    run_pass(1'b0, 1'b0, "sort_clear");
  endtask

  task automatic test_mid_reset();
    bit hit;
    fill_ascending();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      if (out_valid === 1'b1 && out_index === 5'd7) begin
        out_ready = 1'b0;
        rst = 1'b1;
        hit = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!hit) begin
      errors++;
      $display("FAIL mid_reset timeout reaching index 7");
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== 5'd0 || done !== 1'b0 || out_index !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset v=%b busy=%b a=%0d done=%b i=%0d exp 0 0 0 0 0",
               out_valid, busy, mem_addr, done, out_index);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet k=%0d done=%b busy=%b exp 0 0", k, done, busy);
      end
    end
    $display("mid_reset checked");
    run_pass(1'b0, 1'b0, "restart");
  endtask

  task automatic test_start_ignored();
    fill_ascending();
    run_pass(1'b1, 1'b1, "start_spam");
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_random_ready();
    test_sort_check();
    test_mid_reset();
    test_start_ignored();
    checks++;
    if (done_count != 6) begin
      errors++;
      $display("FAIL done_count got=%0d exp=6", done_count);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
